reaction_timer: RTL and testbench
=================================

# reaction_timer

Reaction-time game controller fed by the free-running 5-bit LFSR. On `start`, it samples the LFSR value and converts it to a random wait time. After the wait it lights `led`, then measures in milliseconds how long the player takes to press `btn`. It sits between the LFSR and the display/BCD stage, which consumes `time_ms`, `early` and `timeout`.

## Interface
- `BITWIDTH`, 5: width of `rnd`; must match the LFSR width.
- `TICK_DIV`, 100000: clk cycles per millisecond tick (100 MHz clock).
- `BASE_MS`, 1000: minimum wait in ms.
- `STEP_MS`, 100: wait added per LFSR unit, in ms.
- `MAX_MS`, 9999: saturation and timeout value of `time_ms`.
- `TIME_W`, 14: width of `time_ms`.

Ports:
- `clk`  in  1  clock, rising edge.
- `arst_n`  in  1  reset, asynchronous, active-low.
- `rnd`  in  BITWIDTH  LFSR output, sampled only on an accepted `start`.
- `start`  in  1  synchronous pulse; begins a round.
- `btn`  in  1  debounced, synchronized button level.
- `led`  out  1  high while the player should react.
- `busy`  out  1  high in WAIT and GO.
- `time_ms`  out  TIME_W  latched reaction time.
- `valid`  out  1  one-cycle pulse when a result (normal, early or timeout) is latched.
- `early`  out  1  false-start flag, held until the next round.
- `timeout`  out  1  no-press flag, held until the next round.

## Operation
- **Reset:** state IDLE; `led`, `busy`, `time_ms`, `valid`, `early`, `timeout` = 0. The `btn` history register also resets to 0.
- **Button edge:** `btn_rise` = `btn & ~btn_q`, where `btn_q` is `btn` registered every cycle in all states.
- **IDLE / DONE / EARLY: accepting a round**
  - `start` in any of these states captures `rnd`.
  - Loads `wait_ms` = BASE_MS + `rnd`·STEP_MS, computed at TIME_W+4 bits with no overflow.
  - Clears `early`, `timeout` and `time_ms`, clears the prescaler, and enters WAIT.
  - `btn` is ignored in these states.
- **WAIT**
  - The prescaler counts 0..TICK_DIV-1. On each tick (prescaler == TICK_DIV-1), `wait_ms` decrements.
  - When `wait_ms` reaches 0 on a tick: enter GO, set `led`=1, clear `time_ms` and the prescaler.
  - On `btn_rise`: enter EARLY, set `early`=1, pulse `valid`, leave `led`=0.
- **GO**
  - On each tick, `time_ms` increments.
  - On `btn_rise`: enter DONE, `led`=0, pulse `valid`, hold `time_ms`.
  - If a tick brings `time_ms` to MAX_MS: enter DONE, `timeout`=1, `led`=0, pulse `valid`.
- `start` in WAIT or GO is ignored.
- `rnd` = 0 is legal and gives a wait of BASE_MS.
- **Simultaneous events:**
  - In WAIT, `btn_rise` in the same cycle as wait expiry goes to EARLY. A false start wins.
  - In GO, `btn_rise` in the same cycle as reaching MAX_MS goes to DONE with `time_ms`=MAX_MS and `timeout`=0. The button wins.
  - `start` with `btn_rise` in IDLE: start is accepted and the edge is discarded.
- **Reset mid-round:** `led` drops immediately and asynchronously, all outputs return to their reset values, and no `valid` is emitted.

## Timing
- All outputs are registered.
- `start` sampled high at edge k means `busy`=1 from edge k.
- `led` rises exactly `wait_ms`·TICK_DIV cycles after WAIT entry.
- `time_ms` equals floor(cycles from `led` rise to the edge that samples `btn_rise` / TICK_DIV), saturating at MAX_MS.
- `valid`, `led` fall, `early`/`timeout` and the final `time_ms` all update on the edge that samples the terminating event. `valid` is high for exactly that one cycle.
- `busy` falls on the same edge.
- A new `start` is accepted on the cycle after `valid`.

## Structure
- **Shared package `rt_pkg`:**
  - `state_t` enum: IDLE, WAIT, GO, DONE, EARLY.
  - Default constants: TICK_DIV, BASE_MS, STEP_MS, MAX_MS, TIME_W.
- **One sub-module `tick_gen`:** a prescaler with synchronous `clr` and `en` inputs and a one-cycle `tick` output. It is cleared on WAIT and GO entry and enabled only in WAIT and GO.
- The FSM, `wait_ms` down-counter and `time_ms` up-counter live in `reaction_timer`.

## Test plan
Bench parameters: TICK_DIV=4, BASE_MS=2, STEP_MS=1, MAX_MS=20.
- **Reset:** assert `arst_n`=0 mid-clock → all outputs 0 without a clock edge, state IDLE.
- **Normal round:** `rnd`=5, `start` pulse → `led` rises 28 cycles after WAIT entry. `btn` rises 10 cycles after `led` → `time_ms`=2, `valid` high for 1 cycle, `early`=`timeout`=0.
- **False start:** `btn` rises 8 cycles into WAIT → `early`=1, `valid` pulse, `led` never rises, `time_ms`=0.
- **Timeout:** no `btn` in GO → `time_ms`=20 after 80 cycles, `timeout`=1, `valid` pulse, `led`=0.
- **Start filtering:** `start` during GO is ignored (`led` and count unaffected). `start` in DONE with `rnd`=0 → flags cleared, `led` rises after 8 cycles. A held `btn` entering GO produces no edge.
- **Simultaneous events:** `btn_rise` on the wait-expiry tick → EARLY. `btn_rise` on the MAX_MS tick → `time_ms`=20 with `timeout`=0.

Source files
------------

// File: rtl/reaction_timer_pkg.sv
// rtl/reaction_timer_pkg.sv - shared state encoding and default constants for the reaction timer
package rt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    GO,
    DONE,
    EARLY
  } state_t;

  localparam int DEF_BITWIDTH = 5;
  localparam int DEF_TICK_DIV = 100000;
  localparam int DEF_BASE_MS  = 1000;
  localparam int DEF_STEP_MS  = 100;
  localparam int DEF_MAX_MS   = 9999;
  localparam int DEF_TIME_W   = 14;

endpackage

// File: rtl/reaction_timer_if.sv
// rtl/reaction_timer_if.sv - game control/result bundle between LFSR, player input and display stage
interface reaction_timer_if
  import rt_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int TIME_W   = DEF_TIME_W
);

  logic [BITWIDTH-1:0] rnd;
  logic                start;
  logic                btn;
  logic                led;
  logic                busy;
  logic [TIME_W-1:0]   time_ms;
  logic                valid;
  logic                early;
  logic                timeout;

  modport master (
    output rnd, start, btn,
    input  led, busy, time_ms, valid, early, timeout
  );

  modport slave (
    input  rnd, start, btn,
    output led, busy, time_ms, valid, early, timeout
  );

endinterface

// File: rtl/reaction_timer_tick_gen.sv
// rtl/reaction_timer_tick_gen.sv - millisecond prescaler with synchronous clear and enable
module tick_gen #(
  parameter int TICK_DIV = rt_pkg::DEF_TICK_DIV
) (
  input  logic clk,
  input  logic arst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(TICK_DIV - 1));
  assign o_tick = i_en & w_last;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/reaction_timer.sv
// rtl/reaction_timer.sv - reaction-time game FSM with random wait down-counter and ms reaction counter
module reaction_timer
  import rt_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int BASE_MS  = DEF_BASE_MS,
  parameter int STEP_MS  = DEF_STEP_MS,
  parameter int MAX_MS   = DEF_MAX_MS,
  parameter int TIME_W   = DEF_TIME_W
) (
  input  logic             clk,
  input  logic             arst_n,
  reaction_timer_if.slave  rt
);

  localparam int WAIT_W = TIME_W + 4;

  state_t              r_state, w_state_nxt;
  logic [WAIT_W-1:0]   r_wait_ms, w_wait_nxt, w_wait_load;
  logic [TIME_W-1:0]   r_time_ms, w_time_nxt, w_time_inc;
  logic                r_led, w_led_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_valid, w_valid_nxt;
  logic                r_early, w_early_nxt;
  logic                r_timeout, w_timeout_nxt;
  logic                r_btn_q;
  logic                w_btn_rise;
  logic                w_clr;
  logic                w_tick_en;
  logic                w_tick;
  logic [BITWIDTH-1:0] w_rnd;

  assign w_rnd       = rt.rnd;
  assign w_btn_rise  = rt.btn & ~r_btn_q;
  assign w_wait_load = WAIT_W'(BASE_MS) + WAIT_W'(w_rnd) * WAIT_W'(STEP_MS);
  assign w_time_inc  = w_tick ? r_time_ms + TIME_W'(1) : r_time_ms;
  assign w_tick_en   = (r_state == WAIT) || (r_state == GO);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .arst_n (arst_n),
    .i_clr  (w_clr),
    .i_en   (w_tick_en),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // False start beats wait expiry; in GO the button beats the saturation timeout.
  always_comb begin
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait_ms;
    w_time_nxt    = r_time_ms;
    w_led_nxt     = r_led;
    w_early_nxt   = r_early;
    w_timeout_nxt = r_timeout;
    w_valid_nxt   = 1'b0;
    w_clr         = 1'b0;
    case (r_state)
      IDLE, DONE, EARLY: begin
        if (rt.start) begin
          w_state_nxt   = WAIT;
          w_wait_nxt    = w_wait_load;
          w_time_nxt    = '0;
          w_early_nxt   = 1'b0;
          w_timeout_nxt = 1'b0;
          w_led_nxt     = 1'b0;
          w_clr         = 1'b1;
        end
      end
      WAIT: begin
        if (w_btn_rise) begin
          w_state_nxt = EARLY;
          w_early_nxt = 1'b1;
          w_valid_nxt = 1'b1;
          w_led_nxt   = 1'b0;
        end else if (w_tick) begin
          if (r_wait_ms <= WAIT_W'(1)) begin
            w_state_nxt = GO;
            w_wait_nxt  = '0;
            w_led_nxt   = 1'b1;
            w_time_nxt  = '0;
            w_clr       = 1'b1;
          end else begin
            w_wait_nxt = r_wait_ms - WAIT_W'(1);
          end
        end
      end
      GO: begin
        w_time_nxt = w_time_inc;
        if (w_btn_rise) begin
          w_state_nxt = DONE;
          w_led_nxt   = 1'b0;
          w_valid_nxt = 1'b1;
        end else if (w_tick && (w_time_inc == TIME_W'(MAX_MS))) begin
          w_state_nxt   = DONE;
          w_led_nxt     = 1'b0;
          w_timeout_nxt = 1'b1;
          w_valid_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_busy_nxt = (w_state_nxt == WAIT) || (w_state_nxt == GO);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wait_ms <= '0;
      r_time_ms <= '0;
      r_led     <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_early   <= 1'b0;
      r_timeout <= 1'b0;
      r_btn_q   <= 1'b0;
    end else begin
      r_wait_ms <= w_wait_nxt;
      r_time_ms <= w_time_nxt;
      r_led     <= w_led_nxt;
      r_busy    <= w_busy_nxt;
      r_valid   <= w_valid_nxt;
      r_early   <= w_early_nxt;
      r_timeout <= w_timeout_nxt;
      r_btn_q   <= rt.btn;
    end
  end

  assign rt.led     = r_led;
  assign rt.busy    = r_busy;
  assign rt.time_ms = r_time_ms;
  assign rt.valid   = r_valid;
  assign rt.early   = r_early;
  assign rt.timeout = r_timeout;

endmodule

// File: tb/tb_reaction_timer.sv
// tb/tb_reaction_timer.sv - randomized round-level check of reaction_timer against a timing model
module tb_reaction_timer;

  localparam int BITWIDTH = 5;
  localparam int TICK_DIV = 4;
  localparam int BASE_MS  = 2;
  localparam int STEP_MS  = 1;
  localparam int MAX_MS   = 20;
  localparam int TIME_W   = 14;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  reaction_timer_if #(.BITWIDTH(BITWIDTH), .TIME_W(TIME_W)) u_if ();

  reaction_timer #(
    .BITWIDTH (BITWIDTH),
    .TICK_DIV (TICK_DIV),
    .BASE_MS  (BASE_MS),
    .STEP_MS  (STEP_MS),
    .MAX_MS   (MAX_MS),
    .TIME_W   (TIME_W)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .rt     (u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input int obs, input int exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // Entered and left at a negedge. Edge 0 samples start; press_at is the edge
  // that samples btn_rise (0 = never); held keeps btn high for the whole round.
  task automatic run_round(input int rnd_v, input int press_at, input bit held, input int extra_start);
    int w, tmax, p, exp_led, exp_valid, exp_time, exp_early, exp_to;
    int led_edge, valid_edge, obs_time, obs_early, obs_to;
    w    = (BASE_MS + rnd_v * STEP_MS) * TICK_DIV;
    tmax = w + MAX_MS * TICK_DIV;
    p    = held ? 0 : press_at;
    exp_early = 0;
    exp_to    = 0;
    if (p > 0 && p <= w) begin
      exp_led = -1; exp_valid = p; exp_time = 0; exp_early = 1;
    end else if (p > 0 && p <= tmax) begin
      exp_led = w; exp_valid = p; exp_time = (p - w) / TICK_DIV;
    end else begin
      exp_led = w; exp_valid = tmax; exp_time = MAX_MS; exp_to = 1;
    end

    u_if.rnd   = BITWIDTH'(rnd_v);
    u_if.start = 1'b1;
    u_if.btn   = held;
    @(negedge clk);
    u_if.start = 1'b0;
    u_if.rnd   = BITWIDTH'($urandom);
    chk_eq("busy_on_start", int'(u_if.busy), 1);
    chk_eq("valid_single_cycle", int'(u_if.valid), 0);
    chk_eq("flags_cleared", int'(u_if.early) + int'(u_if.timeout), 0);
    chk_eq("time_cleared", int'(u_if.time_ms), 0);

    led_edge = -1; valid_edge = -1;
    obs_time = 0; obs_early = 0; obs_to = 0;
    for (int n = 1; n <= tmax + 20 && valid_edge < 0; n++) begin
      if (!held && press_at > 0) u_if.btn = (n >= press_at);
      u_if.start = (n == extra_start);
      @(negedge clk);
      if (u_if.led && led_edge < 0) led_edge = n;
      if (u_if.valid) begin
        valid_edge = n;
        obs_time   = int'(u_if.time_ms);
        obs_early  = int'(u_if.early);
        obs_to     = int'(u_if.timeout);
        chk_eq("led_off_at_result", int'(u_if.led), 0);
        chk_eq("busy_off_at_result", int'(u_if.busy), 0);
      end
    end
    u_if.start = 1'b0;
    if (valid_edge < 0) chk_eq("valid_seen_within_budget", 0, 1);
    chk_eq("led_rise_edge", led_edge, exp_led);
    chk_eq("valid_edge", valid_edge, exp_valid);
    chk_eq("time_ms", obs_time, exp_time);
    chk_eq("early", obs_early, exp_early);
    chk_eq("timeout", obs_to, exp_to);
  endtask

  initial begin
    int r, w, tmax, pa, xs;
    bit hd;
    u_if.rnd   = '0;
    u_if.start = 1'b0;
    u_if.btn   = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("reset_led", int'(u_if.led), 0);
    chk_eq("reset_busy", int'(u_if.busy), 0);
    chk_eq("reset_time", int'(u_if.time_ms), 0);
    chk_eq("reset_valid", int'(u_if.valid), 0);
    chk_eq("reset_flags", int'(u_if.early) + int'(u_if.timeout), 0);
    arst_n = 1'b1;
    @(negedge clk);

    run_round(5, 38, 1'b0, 0);        // normal: led at 28, press 10 later
    run_round(5, 8, 1'b0, 0);         // false start
    run_round(3, 0, 1'b0, 0);         // timeout
    run_round(0, 23, 1'b0, 13);       // start in DONE with rnd=0, start in GO ignored
    run_round(2, 0, 1'b1, 0);         // held button never makes an edge
    run_round(4, 24, 1'b0, 0);        // press on the wait-expiry tick
    run_round(1, 92, 1'b0, 0);        // press on the MAX_MS tick

    for (int i = 0; i < 30; i++) begin
      r    = (i % 7 == 0) ? 0 : int'($urandom_range(0, 31));
      w    = (BASE_MS + r * STEP_MS) * TICK_DIV;
      tmax = w + MAX_MS * TICK_DIV;
      case ($urandom_range(0, 5))
        0: pa = 0;
        1: pa = int'($urandom_range(1, w));
        2: pa = w;
        3: pa = int'($urandom_range(w + 1, tmax));
        4: pa = tmax;
        default: pa = tmax + int'($urandom_range(1, 10));
      endcase
      hd = ($urandom_range(0, 7) == 0);
      xs = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, w + 40)) : 0;
      run_round(r, pa, hd, xs);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    u_if.rnd   = '0;
    u_if.start = 1'b1;
    u_if.btn   = 1'b0;
    @(negedge clk);
    u_if.start = 1'b0;
    repeat (10) @(negedge clk);
    chk_eq("led_before_reset", int'(u_if.led), 1);
    #2 arst_n = 1'b0;
    #1;
    chk_eq("async_reset_led", int'(u_if.led), 0);
    chk_eq("async_reset_busy", int'(u_if.busy), 0);
    chk_eq("async_reset_time", int'(u_if.time_ms), 0);
    chk_eq("async_reset_valid", int'(u_if.valid), 0);
    chk_eq("async_reset_flags", int'(u_if.early) + int'(u_if.timeout), 0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    chk_eq("post_reset_idle", int'(u_if.busy) + int'(u_if.valid) + int'(u_if.led), 0);
    run_round(3, 30, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
